mips_io_bridge: RTL and testbench

Memory-mapped I/O bridge sitting directly downstream of the 16-bit MIPS core: it consumes the core's `data_out` write stream, and produces the core's `data_in` word and `interrupt` request. Outbound words are buffered in a small FIFO and drained to an external valid/ready sink. Inbound words from an external valid/ready source are held in a one-word register until the core acknowledges them.

---
 rtl/mips_io_pkg.sv | 22 ++
 rtl/mips_io_ofifo.sv | 69 ++++++
 rtl/mips_io_bridge.sv | 122 ++++++++++++
 tb/tb_mips_io_bridge.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_io_pkg.sv
// ============================================================================
// Module      : mips_io_pkg
// Description : Shared constants and inbound-holder state type for the MIPS
//               memory-mapped I/O bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_io_pkg;

    localparam int MIPS_IO_DATA_W = 16;

    typedef enum logic [0:0] {
        IO_EMPTY = 1'b0,
        IO_HELD  = 1'b1
    } io_state_e;

    localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

endpackage : mips_io_pkg

`default_nettype wire

// File: rtl/mips_io_ofifo.sv
// ============================================================================
// Module      : mips_io_ofifo
// Description : Parameterised synchronous circular FIFO with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_io_ofifo #(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    // Qualify locally so the FIFO can never overflow or underflow.
    assign w_push = push && !full;
    assign w_pop  = pop  && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];

endmodule : mips_io_ofifo

`default_nettype wire

// File: rtl/mips_io_bridge.sv
// ============================================================================
// Module      : mips_io_bridge
// Description : MIPS core I/O bridge: outbound write FIFO to a valid/ready sink,
//               one-word inbound holder from a valid/ready source.
//               Define MIPS_IO_IRQ_EN to drive interrupt from the held state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_io_bridge
    import mips_io_pkg::*;
#(
    parameter int DATA_W      = MIPS_IO_DATA_W,
    parameter int OFIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] core_data_out,
    input  logic              core_wr,
    input  logic              core_rd,
    output logic [DATA_W-1:0] data_in,
    output logic              core_in_valid,
    output logic              interrupt,
    output logic              ofifo_full,
    output logic [7:0]        drop_cnt,
    output logic [DATA_W-1:0] ext_out_data,
    output logic              ext_out_valid,
    input  logic              ext_out_ready,
    input  logic [DATA_W-1:0] ext_in_data,
    input  logic              ext_in_valid,
    output logic              ext_in_ready
);

    localparam int OFIFO_CNT_W = $clog2(OFIFO_DEPTH) + 1;

    logic [DATA_W-1:0]      w_head_data;
    logic                   w_full;
    logic                   w_empty;
    logic [OFIFO_CNT_W-1:0] w_count;
    logic                   w_push;
    logic                   w_pop;

    io_state_e              r_state;
    logic [DATA_W-1:0]      r_data_in;
    logic [7:0]             r_drop_cnt;

    // ------------------------------------------------------------------
    // Outbound path
    // ------------------------------------------------------------------
    assign w_push = core_wr && !w_full;
    assign w_pop  = ext_out_valid && ext_out_ready;

    mips_io_ofifo #(
        .DATA_W (DATA_W),
        .DEPTH  (OFIFO_DEPTH)
    ) u_ofifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (core_data_out),
        .pop       (w_pop),
        .head_data (w_head_data),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    assign ext_out_valid = (w_count != '0);
    // Storage is not reset, so mask the head while empty to present zero.
    assign ext_out_data  = w_empty ? '0 : w_head_data;
    assign ofifo_full    = w_full;

    // Rejected writes use the pre-edge full flag, so a simultaneous pop
    // does not rescue the write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (core_wr && w_full && (r_drop_cnt != DROP_CNT_MAX)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign drop_cnt = r_drop_cnt;

    // ------------------------------------------------------------------
    // Inbound holder
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IO_EMPTY;
            r_data_in <= '0;
        end else begin
            case (r_state)
                IO_EMPTY: begin
                    if (ext_in_valid) begin
                        r_data_in <= ext_in_data;
                        r_state   <= IO_HELD;
                    end
                end
                IO_HELD: begin
                    if (core_rd) begin
                        r_state <= IO_EMPTY;
                    end
                end
                default: r_state <= IO_EMPTY;
            endcase
        end
    end

    assign data_in       = r_data_in;
    assign core_in_valid = (r_state == IO_HELD);
    assign ext_in_ready  = (r_state == IO_EMPTY) && !reset;

`ifdef MIPS_IO_IRQ_EN
    assign interrupt = (r_state == IO_HELD);
`else
    assign interrupt = 1'b0;
`endif

endmodule : mips_io_bridge

`default_nettype wire

// File: tb/tb_mips_io_bridge.sv
// ============================================================================
// Module      : tb_mips_io_bridge
// Description : Directed self-checking bench for mips_io_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_io_bridge;

    localparam bit IRQ_EN =
`ifdef MIPS_IO_IRQ_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [15:0] core_data_out;
    logic        core_wr;
    logic        core_rd;
    logic [15:0] data_in;
    logic        core_in_valid;
    logic        interrupt;
    logic        ofifo_full;
    logic [7:0]  drop_cnt;
    logic [15:0] ext_out_data;
    logic        ext_out_valid;
    logic        ext_out_ready;
    logic [15:0] ext_in_data;
    logic        ext_in_valid;
    logic        ext_in_ready;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_drain [4];

    mips_io_bridge #(
        .DATA_W      (16),
        .OFIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .core_data_out (core_data_out),
        .core_wr       (core_wr),
        .core_rd       (core_rd),
        .data_in       (data_in),
        .core_in_valid (core_in_valid),
        .interrupt     (interrupt),
        .ofifo_full    (ofifo_full),
        .drop_cnt      (drop_cnt),
        .ext_out_data  (ext_out_data),
        .ext_out_valid (ext_out_valid),
        .ext_out_ready (ext_out_ready),
        .ext_in_data   (ext_in_data),
        .ext_in_valid  (ext_in_valid),
        .ext_in_ready  (ext_in_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset         = 1'b1;
        core_data_out = '0;
        core_wr       = 1'b0;
        core_rd       = 1'b0;
        ext_out_ready = 1'b0;
        ext_in_data   = '0;
        ext_in_valid  = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_data_in", 32'(data_in), 32'h0);
        check("rst_in_valid", 32'(core_in_valid), 32'h0);
        check("rst_irq", 32'(interrupt), 32'h0);
        check("rst_out_valid", 32'(ext_out_valid), 32'h0);
        check("rst_out_data", 32'(ext_out_data), 32'h0);
        check("rst_full", 32'(ofifo_full), 32'h0);
        check("rst_drop", 32'(drop_cnt), 32'h0);
        check("rst_in_ready", 32'(ext_in_ready), 32'h0);
        reset = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(ext_in_ready), 32'h1);

        // Fill with 1..4 while sink stalls, then a rejected 5th write
        for (int i = 1; i <= 4; i++) begin
            core_data_out = 16'(i);
            core_wr       = 1'b1;
            tick();
            if (i == 1) begin
                check("lat_out_valid", 32'(ext_out_valid), 32'h1);
                check("lat_out_data", 32'(ext_out_data), 32'h1);
            end
        end
        check("fill_full", 32'(ofifo_full), 32'h1);
        core_data_out = 16'hDEAD;
        tick();
        core_wr = 1'b0;
        check("drop_one", 32'(drop_cnt), 32'h1);
        check("drop_still_full", 32'(ofifo_full), 32'h1);
        ext_out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain1_valid", 32'(ext_out_valid), 32'h1);
            check("drain1_data", 32'(ext_out_data), 32'(i));
            tick();
            if (i == 1) check("pop_frees_full", 32'(ofifo_full), 32'h0);
        end
        ext_out_ready = 1'b0;
        check("drain1_empty", 32'(ext_out_valid), 32'h0);
        check("drain1_empty_data", 32'(ext_out_data), 32'h0);

        // Full + pop + write in the same cycle: pop wins, write rejected
        for (int i = 5; i <= 8; i++) begin
            core_data_out = 16'(i);
            core_wr       = 1'b1;
            tick();
        end
        core_data_out = 16'h0009;
        ext_out_ready = 1'b1;
        tick();
        ext_out_ready = 1'b0;
        core_data_out = 16'h000A;
        check("race_drop", 32'(drop_cnt), 32'h2);
        check("race_not_full", 32'(ofifo_full), 32'h0);
        check("race_head", 32'(ext_out_data), 32'h6);
        tick();
        core_wr = 1'b0;
        check("race_refill_full", 32'(ofifo_full), 32'h1);
        check("race_refill_drop", 32'(drop_cnt), 32'h2);
        exp_drain[0] = 16'h0006;
        exp_drain[1] = 16'h0007;
        exp_drain[2] = 16'h0008;
        exp_drain[3] = 16'h000A;
        ext_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain2_data", 32'(ext_out_data), 32'(exp_drain[i]));
            tick();
        end
        ext_out_ready = 1'b0;
        check("drain2_empty", 32'(ext_out_valid), 32'h0);

        // Inbound capture, back-pressure and release
        ext_in_data  = 16'h1234;
        ext_in_valid = 1'b1;
        tick();
        ext_in_data = 16'h5678;
        check("cap_data", 32'(data_in), 32'h1234);
        check("cap_valid", 32'(core_in_valid), 32'h1);
        check("cap_irq", 32'(interrupt), 32'(IRQ_EN));
        check("cap_ready", 32'(ext_in_ready), 32'h0);
        tick();
        check("wait_data", 32'(data_in), 32'h1234);
        core_rd = 1'b1;
        tick();
        core_rd = 1'b0;
        check("rel_valid", 32'(core_in_valid), 32'h0);
        check("rel_irq", 32'(interrupt), 32'h0);
        check("rel_ready", 32'(ext_in_ready), 32'h1);
        check("rel_data_kept", 32'(data_in), 32'h1234);
        tick();
        ext_in_valid = 1'b0;
        check("cap2_data", 32'(data_in), 32'h5678);
        check("cap2_valid", 32'(core_in_valid), 32'h1);
        check("cap2_irq", 32'(interrupt), 32'(IRQ_EN));
        core_rd = 1'b1;
        tick();
        check("rel2_valid", 32'(core_in_valid), 32'h0);
        check("rel2_data_kept", 32'(data_in), 32'h5678);
        tick();
        core_rd = 1'b0;
        check("rd_empty_ignored", 32'(core_in_valid), 32'h0);
        check("rd_empty_ready", 32'(ext_in_ready), 32'h1);

        // Drop counter saturation
        for (int i = 0; i < 4; i++) begin
            core_data_out = 16'(16'h0011 + i);
            core_wr       = 1'b1;
            tick();
        end
        core_data_out = 16'h0BAD;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 251) check("sat_near", 32'(drop_cnt), 32'd254);
        end
        core_wr = 1'b0;
        check("sat_max", 32'(drop_cnt), 32'd255);
        check("sat_head", 32'(ext_out_data), 32'h0011);

        // Reset with FIFO half full and a word held
        ext_out_ready = 1'b1;
        tick();
        tick();
        ext_out_ready = 1'b0;
        check("half_head", 32'(ext_out_data), 32'h0013);
        check("half_not_full", 32'(ofifo_full), 32'h0);
        ext_in_data  = 16'hBEEF;
        ext_in_valid = 1'b1;
        tick();
        ext_in_valid = 1'b0;
        check("pre_rst_held", 32'(data_in), 32'hBEEF);
        reset = 1'b1;
        tick();
        check("mid_rst_data_in", 32'(data_in), 32'h0);
        check("mid_rst_in_valid", 32'(core_in_valid), 32'h0);
        check("mid_rst_irq", 32'(interrupt), 32'h0);
        check("mid_rst_out_valid", 32'(ext_out_valid), 32'h0);
        check("mid_rst_out_data", 32'(ext_out_data), 32'h0);
        check("mid_rst_full", 32'(ofifo_full), 32'h0);
        check("mid_rst_drop", 32'(drop_cnt), 32'h0);
        check("mid_rst_in_ready", 32'(ext_in_ready), 32'h0);
        reset = 1'b0;
        tick();
        check("after_rst_in_ready", 32'(ext_in_ready), 32'h1);
        check("after_rst_empty", 32'(ext_out_valid), 32'h0);
        core_data_out = 16'h00C3;
        core_wr       = 1'b1;
        tick();
        core_wr = 1'b0;
        check("after_rst_head", 32'(ext_out_data), 32'h00C3);
        ext_out_ready = 1'b1;
        tick();
        ext_out_ready = 1'b0;
        check("after_rst_single", 32'(ext_out_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mips_io_bridge

`default_nettype wire
